minibus_sram_slave: RTL and testbench
=====================================

MINIBUS_SRAM_SLAVE -- requirements
Module: minibus_sram_slave

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words of backing storage; power of two, 16..4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; legal range 0..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sel  input  1  slave select from the minibus decoder; high when req_addr falls in this slave's window.
REQ-007 req_ren  input  1  master read request; held until res_ready.
REQ-008 req_wen  input  1  master write request; held until res_ready.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_strobe  input  4  byte-lane write enables; bit n covers wdata[8n+7:8n].
REQ-012 res_rdata  output  32  read data; valid only while res_ready.
REQ-013 res_ready  output  1  one-cycle completion pulse.
REQ-014 res_error  output  1  error flag; valid only while res_ready.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 In IDLE, sel && (req_ren || req_wen) SHALL accept the request: latch addr, wdata, strobe, ren, wen.
REQ-017 On accept, next state SHALL be WAIT with wait counter loaded to WAIT_CYCLES, or RESP directly if WAIT_CYCLES==0.
REQ-018 WAIT SHALL decrement the counter each cycle and move to RESP in the cycle after the counter reaches 1 (exactly WAIT_CYCLES cycles in WAIT).
REQ-019 Latency SHALL be exactly 1+WAIT_CYCLES cycles: request accepted at edge T, res_ready high in cycle T+1+WAIT_CYCLES.
REQ-020 RESP SHALL last exactly one cycle with res_ready=1, then return to IDLE unconditionally.
REQ-021 A request still asserted in the IDLE cycle after RESP SHALL be treated as a new transaction (minimum one idle cycle between transactions).
REQ-022 Latched fields SHALL be used for the whole transaction; changes to req_* or deassertion of sel during WAIT/RESP SHALL be ignored.
REQ-023 Word index SHALL be (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
REQ-024 Error condition: addr[1:0] != 0, or addr < BASE_ADDR, or (addr - BASE_ADDR) >= DEPTH*4, or ren && wen both high.
REQ-025 On error, RESP SHALL assert res_error=1 and res_rdata=0, with no storage modification.
REQ-026 Valid write: in the RESP cycle, only bytes with strobe bit set SHALL be updated; strobe=4'b0000 SHALL complete with no change and res_error=0.
REQ-027 Valid read: res_rdata in RESP SHALL equal storage contents at the latched index, including a write completed in the immediately preceding transaction.
REQ-028 Outside RESP, res_ready, res_error, res_rdata SHALL be 0.
REQ-029 Requests with sel=0 SHALL never be accepted and SHALL produce no response.

Reset
REQ-030 rst high at an edge SHALL force IDLE, counter 0, and res_ready=res_error=0, res_rdata=0 in the following cycle, regardless of state.
REQ-031 Reset mid-transaction SHALL abort it: no response and no write (even if reset coincides with RESP).
REQ-032 Storage contents SHALL NOT be reset; reads before any write return undefined data (benches write before reading).

Verification
REQ-033 WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, strobe 4'hF, then read 0x10 -> each res_ready in cycle T+3, read rdata 0xDEADBEEF, error 0.
REQ-034 Byte strobe: write 0x11223344 to 0x20, then 0xAABBCCDD with strobe 4'b0101 -> read returns 0x11BB33DD.
REQ-035 Errors: read 0x22 (misaligned), read BASE_ADDR+DEPTH*4 (out of range), ren&&wen at 0x0 -> res_ready=1, res_error=1, rdata 0; memory at 0x0 unchanged.
REQ-036 WAIT_CYCLES=0 back-to-back: request held continuously -> res_ready pulses every 2 cycles, never two consecutive cycles.
REQ-037 Reset during WAIT of write 0x55555555 to 0x30 (prior value 0x0) -> no res_ready; subsequent read of 0x30 returns 0x00000000.
REQ-038 sel=0 with req_ren=1 for 20 cycles -> res_ready stays 0; sel dropped during WAIT of accepted read -> response still delivered on schedule.

Source files
------------

// File: rtl/minibus_sram_slave.sv
// Minibus SRAM slave: word-wide storage with byte-strobe writes and a fixed,
// parameterised response latency of 1+WAIT_CYCLES cycles.
module minibus_sram_slave #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_strobe,
  output logic [31:0] o_res_rdata,
  output logic        o_res_ready,
  output logic        o_res_error
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strobe;
  logic        r_ren;
  logic        r_wen;
  logic [31:0] r_mem [DEPTH];

  logic          w_acc;
  logic [31:0]   w_addr;
  logic          w_ren;
  logic          w_wen;
  logic [32:0]   w_diff;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd;

  // In IDLE the live request is decoded so a zero-wait response can be formed
  // on the accepting edge; afterwards only the latched copy is used.
  assign w_acc  = (r_state == IDLE) && i_sel && (i_req_ren || i_req_wen);
  assign w_addr = (r_state == IDLE) ? i_req_addr : r_addr;
  assign w_ren  = (r_state == IDLE) ? i_req_ren  : r_ren;
  assign w_wen  = (r_state == IDLE) ? i_req_wen  : r_wen;
  assign w_diff = {1'b0, w_addr} - {1'b0, BASE_ADDR};
  assign w_err  = (w_addr[1:0] != 2'b00) || w_diff[32] || (w_diff[31:0] >= SPAN)
                  || (w_ren && w_wen);
  assign w_idx  = w_diff[AW+1:2];
  assign w_rd   = (w_ren && !w_err) ? r_mem[w_idx] : 32'h0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_strobe    <= 4'h0;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      o_res_ready <= 1'b0;
      o_res_error <= 1'b0;
      o_res_rdata <= 32'h0;
    end else begin
      o_res_ready <= 1'b0;
      o_res_error <= 1'b0;
      o_res_rdata <= 32'h0;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_strobe <= i_req_strobe;
            r_ren    <= i_req_ren;
            r_wen    <= i_req_wen;
            if (WAIT_INIT == 4'd0) begin
              r_state     <= RESP;
              o_res_ready <= 1'b1;
              o_res_error <= w_err;
              o_res_rdata <= w_rd;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= RESP;
            r_cnt       <= 4'd0;
            o_res_ready <= 1'b1;
            o_res_error <= w_err;
            o_res_rdata <= w_rd;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Writes commit on the edge that closes RESP, so a reset landing there aborts them.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == RESP) && r_wen && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strobe[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_minibus_sram_slave.sv
// Bench for minibus_sram_slave: a schedule-based reference model checked every
// cycle, directed transactions with literal expectations, and a zero-wait instance.
module tb_minibus_sram_slave;

  localparam int          W     = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, sel, ren, wen;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata, rdata0;
  logic        ready, error, ready0, error0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  minibus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_req_ren(ren), .i_req_wen(wen),
    .i_req_addr(addr), .i_req_wdata(wdata), .i_req_strobe(strobe),
    .o_res_rdata(rdata), .o_res_ready(ready), .o_res_error(error)
  );

  minibus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_req_ren(ren), .i_req_wen(wen),
    .i_req_addr(addr), .i_req_wdata(wdata), .i_req_strobe(strobe),
    .o_res_rdata(rdata0), .o_res_ready(ready0), .o_res_error(error0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic isErr(input logic [31:0] a, input logic r, input logic w);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a[1:0] != 2'b00) || (off < 0) || (off >= longint'(DEPTH) * 4) || (r && w);
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Reference model: a transaction accepted at edge e responds after edge e+W,
  // finishes (and commits any write) at the next edge, then the slave is free.
  logic [31:0] mMem [int];
  logic        mBusy = 1'b0;
  int          edgeN = 0;
  int          respEdge = 0;
  logic [31:0] mAddr, mWdata;
  logic [3:0]  mStrobe;
  logic        mRen, mWen;
  logic        expReady = 1'b0, expErr = 1'b0, expKnown = 1'b1;
  logic [31:0] expData = 32'h0;

  always @(posedge clk) begin
    int          i;
    logic [31:0] v;
    edgeN++;
    if (rst) begin
      mBusy = 1'b0; expReady = 1'b0; expErr = 1'b0; expData = 32'h0; expKnown = 1'b1;
    end else if (expReady) begin
      if (mWen && !isErr(mAddr, mRen, mWen)) begin
        i = idxOf(mAddr);
        v = mMem.exists(i) ? mMem[i] : 32'h0;
        for (int b = 0; b < 4; b++) if (mStrobe[b]) v[8*b +: 8] = mWdata[8*b +: 8];
        mMem[i] = v;
      end
      mBusy = 1'b0; expReady = 1'b0; expErr = 1'b0; expData = 32'h0; expKnown = 1'b1;
    end else begin
      if (!mBusy && sel && (ren || wen)) begin
        mAddr = addr; mWdata = wdata; mStrobe = strobe; mRen = ren; mWen = wen;
        mBusy = 1'b1;
        respEdge = edgeN + W;
      end
      if (mBusy && edgeN == respEdge) begin
        i = idxOf(mAddr);
        expReady = 1'b1;
        expErr   = isErr(mAddr, mRen, mWen);
        expKnown = expErr || !mRen || mMem.exists(i);
        expData  = (!expErr && mRen && mMem.exists(i)) ? mMem[i] : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model ready", {31'h0, ready}, {31'h0, expReady});
    checkOutput("model error", {31'h0, error}, {31'h0, expErr});
    if (expKnown) checkOutput("model rdata", rdata, expData);
  end

  // Issues one request from a negedge and holds it until the response is seen.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic r, input logic w, input logic chg,
                               output logic [31:0] rd, output logic err, output int lat);
    logic got;
    sel = 1'b1; ren = r; wen = w; addr = a; wdata = d; strobe = s;
    lat = 0; got = 1'b0; rd = 32'h0; err = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (chg && lat == 1) begin
        sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'h44; wdata = 32'h0;
      end
      if (ready) begin
        got = 1'b1; rd = rdata; err = error;
      end
    end
    sel = 1'b0; ren = 1'b0; wen = 1'b0;
    checkOutput("response seen", {31'h0, got}, 32'h1);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic        got;

  initial begin
    rst = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0;
    addr = 32'h0; wdata = 32'h0; strobe = 4'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset ready", {31'h0, ready}, 32'h0);
    checkOutput("reset error", {31'h0, error}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    rst = 1'b0;

    applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, rd, err, lat);
    checkOutput("write latency", lat, 32'd3);
    checkOutput("write error", {31'h0, err}, 32'h0);
    applyStimulus(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("read latency", lat, 32'd3);
    checkOutput("read data", rd, 32'hDEADBEEF);
    checkOutput("read error", {31'h0, err}, 32'h0);

    applyStimulus(32'h20, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b0, rd, err, lat);
    applyStimulus(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b1, 1'b0, rd, err, lat);
    applyStimulus(32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("strobe merge", rd, 32'h11BB33DD);
    applyStimulus(32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 1'b0, rd, err, lat);
    checkOutput("zero strobe error", {31'h0, err}, 32'h0);
    applyStimulus(32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("zero strobe keep", rd, 32'h11BB33DD);

    applyStimulus(32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b0, rd, err, lat);
    applyStimulus(32'h22, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("misaligned error", {31'h0, err}, 32'h1);
    checkOutput("misaligned rdata", rd, 32'h0);
    applyStimulus(BASE + DEPTH * 4, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("range error", {31'h0, err}, 32'h1);
    checkOutput("range rdata", rd, 32'h0);
    applyStimulus(32'h0, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, rd, err, lat);
    checkOutput("ren wen error", {31'h0, err}, 32'h1);
    checkOutput("ren wen rdata", rd, 32'h0);
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("error no write", rd, 32'hCAFEF00D);

    sel = 1'b0; ren = 1'b1; addr = 32'h10;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("unselected ready", {31'h0, ready}, 32'h0);
    end
    ren = 1'b0;
    @(negedge clk);

    applyStimulus(32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, rd, err, lat);
    checkOutput("sel drop latency", lat, 32'd3);
    checkOutput("sel drop data", rd, 32'h11BB33DD);

    applyStimulus(32'h30, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, rd, err, lat);
    sel = 1'b1; wen = 1'b1; addr = 32'h30; wdata = 32'h55555555; strobe = 4'hF;
    @(negedge clk);
    rst = 1'b1; sel = 1'b0; wen = 1'b0;
    @(negedge clk);
    checkOutput("abort ready", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(32'h30, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("aborted write", rd, 32'h0);

    applyStimulus(32'h34, 32'h1, 4'hF, 1'b0, 1'b1, 1'b0, rd, err, lat);
    sel = 1'b1; wen = 1'b1; addr = 32'h34; wdata = 32'h77; strobe = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    checkOutput("resp before reset", {31'h0, got}, 32'h1);
    rst = 1'b1; sel = 1'b0; wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(32'h34, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, err, lat);
    checkOutput("reset in resp", rd, 32'h1);

    repeat (3) @(negedge clk);
    sel = 1'b1; ren = 1'b1; addr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput("zero wait ready", {31'h0, ready0}, 32'(k % 2));
      checkOutput("zero wait rdata", rdata0, (k % 2 == 1) ? 32'hDEADBEEF : 32'h0);
    end
    sel = 1'b0; ren = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
